// File: rtl/zseq_checker_pkg.sv
// ----------------------------------------------------------------------------
// zseq_checker_pkg
//
// Shared definitions for the Z-sequence checker and its golden model:
//   - zseq_state_e      : checker FSM states (HUNT / CHECK / LOCKED), 2 bits
//   - zseq_f()          : the 3-stage generator output function
//   - ZSEQ_REF_PATTERN  : one period of the A=1 stream starting from 000,
//                         first bit in the MSB (1,0,1,1,1,0,0,0)
// ----------------------------------------------------------------------------
package zseq_checker_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } zseq_state_e;

   localparam logic [7:0] ZSEQ_REF_PATTERN = 8'b1011_1000;

   // Generator output for history {h2,h1,h0}: Z = ~(h2|h1) ^ (h1^h0).
   function automatic logic zseq_f(input logic h2, input logic h1, input logic h0);
      return (~(h2 | h1)) ^ (h1 ^ h0);
   endfunction

endpackage : zseq_checker_pkg

// File: rtl/zseq_model.sv
// ----------------------------------------------------------------------------
// zseq_model
//
// 3-bit history register mirroring the generator state {q2,q1,q0}, plus the
// combinational prediction of the next Z bit from that history. The caller
// decides which bit is shifted in (received bit or flywheel prediction).
//
// Ports:
//   clk        in   clock, posedge
//   rst_n      in   synchronous active-low reset, clears history to 000
//   shift_en   in   shift shift_bit into h2 this cycle
//   shift_bit  in   new h2 value (already gated with A by the caller)
//   hist       out  current history {h2,h1,h0}
//   exp_bit    out  predicted Z for the current history
// ----------------------------------------------------------------------------
module zseq_model
   import zseq_checker_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       shift_en,
   input  logic       shift_bit,
   output logic [2:0] hist,
   output logic       exp_bit
);

   logic [2:0] hist_q;
   logic [2:0] hist_d;

   // Next history: shift toward h0 when enabled, otherwise hold.
   always_comb begin
      hist_d = hist_q;
      if (shift_en) begin
         hist_d = {shift_bit, hist_q[2], hist_q[1]};
      end else begin
         hist_d = hist_q;
      end
   end

   // History register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_q <= 3'b000;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign hist    = hist_q;
   assign exp_bit = zseq_f(hist_q[2], hist_q[1], hist_q[0]);

endmodule : zseq_model

// File: rtl/zseq_checker.sv
// ----------------------------------------------------------------------------
// zseq_checker
//
// Receive-side checker for the serial Z-sequence stream. Rebuilds the
// generator state from received history, predicts each bit, and tracks
// HUNT -> CHECK -> LOCKED with a flywheel once locked.
//
// Parameters:
//   LOCK_N  consecutive matches in CHECK needed to lock        (1..255)
//   LOSS_N  consecutive misses in LOCKED that drop to HUNT      (1..15)
//   ERR_W   width of the saturating error counter
//
// Ports:
//   Clk      in   clock, posedge
//   Rst_n    in   synchronous active-low reset
//   Din      in   received Z bit
//   Din_vld  in   qualifies Din/A_in; nothing advances while low
//   A_in     in   generator mode bit for the same bit slot
//   Exp      out  combinational prediction of the current Din
//   Err      out  registered one-cycle mismatch pulse
//   Lock     out  registered, high while LOCKED
//   Err_cnt  out  registered saturating mismatch count
//   Hist     out  current history {h2,h1,h0}
// ----------------------------------------------------------------------------
module zseq_checker
   import zseq_checker_pkg::*;
#(
   parameter int LOCK_N = 8,
   parameter int LOSS_N = 3,
   parameter int ERR_W  = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Din,
   input  logic             Din_vld,
   input  logic             A_in,
   output logic             Exp,
   output logic             Err,
   output logic             Lock,
   output logic [ERR_W-1:0] Err_cnt,
   output logic [2:0]       Hist
);

   localparam logic [7:0]       LOCK_N_C = 8'(LOCK_N);
   localparam logic [3:0]       LOSS_N_C = 4'(LOSS_N);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

   zseq_state_e      state_q,   state_d;
   logic [1:0]       fill_q,    fill_d;
   logic [7:0]       match_q,   match_d;
   logic [3:0]       miss_q,    miss_d;
   logic             err_q,     err_d;
   logic             lock_q,    lock_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic       exp_s;
   logic [2:0] hist_s;
   logic       mismatch_s;
   logic       shift_bit_s;

   // Once locked, history is fed from the prediction so a corrupted bit
   // cannot knock the flywheel out of step; otherwise it follows the line.
   always_comb begin
      mismatch_s = Din ^ exp_s;
      if (state_q == ST_LOCKED) begin
         shift_bit_s = A_in & exp_s;
      end else begin
         shift_bit_s = A_in & Din;
      end
   end

   zseq_model u_model (
      .clk       (Clk),
      .rst_n     (Rst_n),
      .shift_en  (Din_vld),
      .shift_bit (shift_bit_s),
      .hist      (hist_s),
      .exp_bit   (exp_s)
   );

   // Next-state, counter and status computation for one qualified bit.
   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      match_d   = match_q;
      miss_d    = miss_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;

      if (Din_vld) begin
         case (state_q)
            ST_HUNT: begin
               // Third fill bit completes the history; start checking.
               if (fill_q == 2'd2) begin
                  state_d = ST_CHECK;
                  fill_d  = 2'd0;
                  match_d = 8'd0;
               end else begin
                  fill_d  = fill_q + 2'd1;
               end
            end

            ST_CHECK: begin
               if (!mismatch_s) begin
                  if ((match_q + 8'd1) == LOCK_N_C) begin
                     state_d = ST_LOCKED;
                     match_d = 8'd0;
                     miss_d  = 4'd0;
                  end else begin
                     match_d = match_q + 8'd1;
                  end
               end else begin
                  err_d   = 1'b1;
                  match_d = 8'd0;
                  if (err_cnt_q != ERR_MAX) begin
                     err_cnt_d = err_cnt_q + ERR_ONE;
                  end else begin
                     err_cnt_d = err_cnt_q;
                  end
               end
            end

            ST_LOCKED: begin
               if (mismatch_s) begin
                  err_d = 1'b1;
                  if (err_cnt_q != ERR_MAX) begin
                     err_cnt_d = err_cnt_q + ERR_ONE;
                  end else begin
                     err_cnt_d = err_cnt_q;
                  end
                  if ((miss_q + 4'd1) == LOSS_N_C) begin
                     state_d = ST_HUNT;
                     fill_d  = 2'd0;
                     match_d = 8'd0;
                     miss_d  = 4'd0;
                  end else begin
                     miss_d  = miss_q + 4'd1;
                  end
               end else begin
                  miss_d = 4'd0;
               end
            end

            default: begin
               // Unreachable encoding: recover by hunting again.
               state_d = ST_HUNT;
               fill_d  = 2'd0;
               match_d = 8'd0;
               miss_d  = 4'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      lock_d = (state_d == ST_LOCKED);
   end

   // State, counters and registered status outputs.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q   <= ST_HUNT;
         fill_q    <= 2'd0;
         match_q   <= 8'd0;
         miss_q    <= 4'd0;
         err_q     <= 1'b0;
         lock_q    <= 1'b0;
         err_cnt_q <= {ERR_W{1'b0}};
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         miss_q    <= miss_d;
         err_q     <= err_d;
         lock_q    <= lock_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign Exp     = exp_s;
   assign Err     = err_q;
   assign Lock    = lock_q;
   assign Err_cnt = err_cnt_q;
   assign Hist    = hist_s;

endmodule : zseq_checker

// File: tb/tb_zseq_checker.sv
// ----------------------------------------------------------------------------
// tb_zseq_checker
//
// Scoreboard bench for zseq_checker (LOCK_N=8, LOSS_N=3, ERR_W=8). A bench
// generator produces the line stream; a behavioural reference computes the
// expected Err/Lock/Err_cnt/Hist, which are queued when a bit is driven and
// compared after the consuming edge.
// ----------------------------------------------------------------------------
module tb_zseq_checker;

   localparam int LOCK_N = 8;
   localparam int LOSS_N = 3;
   localparam int ERR_W  = 8;

   logic             Clk = 1'b0;
   logic             Rst_n = 1'b0;
   logic             Din = 1'b0;
   logic             Din_vld = 1'b0;
   logic             A_in = 1'b0;
   logic             Exp;
   logic             Err;
   logic             Lock;
   logic [ERR_W-1:0] Err_cnt;
   logic [2:0]       Hist;

   zseq_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .ERR_W(ERR_W)) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Din     (Din),
      .Din_vld (Din_vld),
      .A_in    (A_in),
      .Exp     (Exp),
      .Err     (Err),
      .Lock    (Lock),
      .Err_cnt (Err_cnt),
      .Hist    (Hist)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       err;
      logic       lock;
      logic [7:0] cnt;
      logic [2:0] hist;
   } sb_t;

   sb_t sb_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // Z for history index {h2,h1,h0}: 000->1 001->0 010->1 011->0
   // 100->0 101->1 110->1 111->0
   logic [7:0] ztab = 8'b0110_0101;

   // reference checker state
   int         m_state;   // 0 hunt, 1 check, 2 locked
   logic [2:0] m_h;
   int         m_fill, m_match, m_miss, m_cnt;
   logic       m_err;
   // bench-side generator
   logic [2:0] g;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, req, $time);
      end
   endtask

   function automatic logic m_exp();
      return ztab[m_h];
   endfunction

   task automatic model_reset();
      m_state = 0; m_h = 3'b000; m_fill = 0; m_match = 0; m_miss = 0;
      m_cnt = 0; m_err = 1'b0; g = 3'b000;
   endtask

   task automatic model_step(input logic vld, input logic a, input logic d);
      logic e;
      m_err = 1'b0;
      if (vld) begin
         e = m_exp();
         if (m_state == 0) begin
            m_h = {a & d, m_h[2:1]};
            m_fill++;
            if (m_fill == 3) begin m_state = 1; m_fill = 0; m_match = 0; end
         end else if (m_state == 1) begin
            m_h = {a & d, m_h[2:1]};
            if (d == e) begin
               m_match++;
               if (m_match == LOCK_N) begin m_state = 2; m_miss = 0; m_match = 0; end
            end else begin
               m_err = 1'b1; m_match = 0;
               if (m_cnt < 255) m_cnt++;
            end
         end else begin
            m_h = {a & e, m_h[2:1]};
            if (d != e) begin
               m_err = 1'b1; m_miss++;
               if (m_cnt < 255) m_cnt++;
               if (m_miss == LOSS_N) begin m_state = 0; m_fill = 0; m_miss = 0; end
            end else begin
               m_miss = 0;
            end
         end
      end
   endtask

   // Drive one slot, check Exp in-cycle, queue the expectation, then
   // compare after the consuming edge.
   task automatic drive_bit(input logic vld, input logic a, input logic d);
      sb_t s;
      @(negedge Clk);
      Din_vld = vld; A_in = a; Din = d;
      #1;
      check("exp", 32'(Exp), 32'(m_exp()));
      model_step(vld, a, d);
      s.err = m_err; s.lock = (m_state == 2); s.cnt = 8'(m_cnt); s.hist = m_h;
      sb_q.push_back(s);
      @(posedge Clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         s = sb_q.pop_front();
         check("err",     32'(Err),     32'(s.err));
         check("lock",    32'(Lock),    32'(s.lock));
         check("err_cnt", 32'(Err_cnt), 32'(s.cnt));
         check("hist",    32'(Hist),    32'(s.hist));
      end
   endtask

   // Next generator bit, optionally inverted on the line.
   task automatic gen_bit(input logic a, input logic flip);
      logic z;
      z = ztab[g];
      g = {a & z, g[2:1]};
      drive_bit(1'b1, a, z ^ flip);
   endtask

   task automatic do_reset(input logic vld_during);
      @(negedge Clk);
      Rst_n = 1'b0; Din_vld = vld_during; Din = 1'b0; A_in = 1'b1;
      @(posedge Clk);
      #1;
      Rst_n = 1'b1; Din_vld = 1'b0;
      model_reset();
      sb_q.delete();
      check("rst_err",  32'(Err),     32'd0);
      check("rst_lock", 32'(Lock),    32'd0);
      check("rst_cnt",  32'(Err_cnt), 32'd0);
      check("rst_hist", 32'(Hist),    32'd0);
      check("rst_exp",  32'(Exp),     32'd1);
   endtask

   initial begin
      model_reset();
      do_reset(1'b0);

      // Fill: 1,0,1 with A=1
      for (int i = 0; i < 3; i++) gen_bit(1'b1, 1'b0);
      check("fill_hist", 32'(Hist), 32'h5);
      check("fill_err",  32'(Err),  32'd0);

      // 8 matches -> lock on bit 11
      for (int i = 3; i < 11; i++) begin
         if (i == 10) check("lock_before_11", 32'(Lock), 32'd0);
         gen_bit(1'b1, 1'b0);
      end
      check("lock_at_11", 32'(Lock), 32'd1);
      check("cnt_clean",  32'(Err_cnt), 32'd0);

      // Single flipped bit while locked, then a gap, then clean bits
      gen_bit(1'b1, 1'b1);
      check("flip_err",  32'(Err),     32'd1);
      check("flip_cnt",  32'(Err_cnt), 32'd1);
      check("flip_lock", 32'(Lock),    32'd1);
      drive_bit(1'b0, 1'b1, 1'b0);
      check("gap_err", 32'(Err), 32'd0);
      for (int i = 0; i < 6; i++) gen_bit(1'b1, 1'b0);
      check("flywheel_cnt", 32'(Err_cnt), 32'd1);

      // Reset mid-LOCKED with a valid bit on the same edge
      do_reset(1'b1);

      // Relock, then three flipped bits drop to HUNT, relock after 11 more
      for (int i = 0; i < 11; i++) gen_bit(1'b1, 1'b0);
      check("relock_a", 32'(Lock), 32'd1);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) check("lock_before_loss", 32'(Lock), 32'd1);
         gen_bit(1'b1, 1'b1);
      end
      check("loss_lock", 32'(Lock),    32'd0);
      check("loss_cnt",  32'(Err_cnt), 32'd3);
      for (int i = 0; i < 11; i++) begin
         if (i == 10) check("relock_before_11", 32'(Lock), 32'd0);
         gen_bit(1'b1, 1'b0);
      end
      check("relock_b", 32'(Lock), 32'd1);

      // A=0 decay with random Din_vld gaps
      for (int i = 0; i < 10; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int k = 0; k < gap; k++) drive_bit(1'b0, 1'($urandom), 1'($urandom));
         gen_bit(1'b0, 1'b0);
      end
      check("decay_hist", 32'(Hist),    32'd0);
      check("decay_exp",  32'(Exp),     32'd1);
      check("decay_cnt",  32'(Err_cnt), 32'd3);
      check("decay_lock", 32'(Lock),    32'd1);

      // Saturation: 300 forced mismatches in CHECK
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) gen_bit(1'b1, 1'b0);
      for (int i = 0; i < 300; i++) drive_bit(1'b1, 1'b1, ~m_exp());
      check("sat_cnt", 32'(Err_cnt), 32'd255);
      check("sat_err", 32'(Err),     32'd1);

      // Reset mid-stream
      do_reset(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_zseq_checker
